button_mode_sequencer: RTL and testbench
========================================

Name: button_mode_sequencer

Overview:
- Front-end controller for the watch cores.
- Synchronizes and debounces the four raw buttons, then produces single-cycle command pulses.
- Owns st_mux: decides which core (clock = 0, others 1..3) currently receives button commands.
- Adds auto-repeat on up/down, and an idle timeout that returns control to the clock core.

Parameters:
- NUM_CORES, 4: number of cores selectable via st_mux; legal range 1..4.
- DEBOUNCE, 4: consecutive clk_tick cycles a synchronized level must be stable before it is accepted.
- REPEAT_DELAY, 50: cycles from an accepted up/down pulse to the first repeat pulse while the key is held.
- REPEAT_RATE, 10: cycles between subsequent repeat pulses.
- IDLE_TICKS, 3000: cycles without an accepted event before auto-return to core 0.

Ports:
- clk_tick  in  1  : sole clock; all state updates on rising edge.
- rst  in  1  : synchronous, active-high reset.
- btn_mode  in  1  : raw mode button, asynchronous.
- btn_set  in  1  : raw set button, asynchronous.
- btn_up  in  1  : raw up button, asynchronous.
- btn_down  in  1  : raw down button, asynchronous.
- core_busy  in  4  : bit i high while core i is in a set/halt state; bits at or above NUM_CORES are ignored.
- st_mux  out  2  : index of the core owning the buttons.
- mode_p  out  1  : one-cycle mode command.
- set_p  out  1  : one-cycle set command.
- up_p  out  1  : one-cycle up command.
- down_p  out  1  : one-cycle down command.

Behaviour:
- Reset (rst high at a clock edge):
  - st_mux=0; all pulse outputs 0.
  - Synchronizers, debounced levels and their delayed copies = 0.
  - All counters = 0; repeat FSM = IDLE.
  - A button held through reset yields one press DEBOUNCE+3 edges after rst falls.
- Per-button input path:
  - 2-flop synchronizer gives s2.
  - Debounce counter increments while s2 != deb and clears when s2 == deb.
  - When the counter reaches DEBOUNCE-1 with s2 != deb: deb <= s2 and the counter clears.
  - Press event = deb high and deb_d low (registered).
  - Latency: the pulse is high exactly one cycle, beginning DEBOUNCE+3 edges after the first edge that samples the raw level high (7 edges at DEBOUNCE=4).
  - Glitches shorter than DEBOUNCE cycles produce nothing.
- Arbitration of press events in one cycle:
  - Priority mode > set > up > down.
  - Exactly one pulse output can be high per cycle; losing events are dropped, not queued.
  - A repeat pulse counts as an up/down event and loses to a same-cycle mode or set press.
- Mode handling (accepted mode press):
  - mode_p is pulsed.
  - If core_busy[st_mux]=0, st_mux advances to st_mux+1, wrapping from NUM_CORES-1 to 0. The update lands on the same edge that raises mode_p.
  - If the current core is busy, st_mux is unchanged.
- Repeat FSM (up/down only):
  - IDLE -> HOLD on an accepted up/down press; latch which key and clear the counter.
  - HOLD: when the counter reaches REPEAT_DELAY-1, emit a pulse of the latched key and go to REPEAT.
  - REPEAT: emit a pulse every REPEAT_RATE cycles.
  - From HOLD or REPEAT, go to IDLE on: release of the latched key (deb low), any accepted press of another key, or a mode-driven st_mux change.
  - Counters saturate, never wrap.
- Idle timer:
  - Clears on every accepted event, including repeats; otherwise increments, saturating at IDLE_TICKS.
  - At saturation with st_mux != 0 and core_busy[st_mux]=0: st_mux <= 0, the timer clears, no pulse is emitted.
  - While the current core is busy, the timer holds at saturation and return happens on the first non-busy cycle.
  - With st_mux = 0 the timer simply stays saturated.
- Simultaneous events:
  - Mode press and timeout in the same cycle: the mode press wins and the timer clears.
  - rst dominates everything.

Test Plan:
(Parameters for all scenarios: DEBOUNCE=4, REPEAT_DELAY=8, REPEAT_RATE=3, IDLE_TICKS=20, NUM_CORES=4.)
- Debounce and latency:
  - Stimulus: btn_set high for 3 cycles, low; then high for 12 cycles.
  - Required: no pulse from the 3-cycle glitch; set_p high exactly one cycle, 7 edges after the second rise.
- Mode wrap and busy hold:
  - Stimulus: 4 clean mode presses, core_busy=0.
  - Required: st_mux 1, 2, 3, 0, with mode_p on each.
  - Stimulus: set core_busy[1]=1 with st_mux=1, then press mode.
  - Required: mode_p pulses, st_mux stays 1.
- Auto-repeat:
  - Stimulus: hold btn_up for 30 cycles after the first up_p at cycle T.
  - Required: further up_p at T+8, T+11, T+14, ...; none after release is debounced.
  - Stimulus: press down during the up repeat.
  - Required: repeat stops, one down_p.
- Priority:
  - Stimulus: btn_mode and btn_up rise in the same cycle.
  - Required: only mode_p, no up_p that cycle, repeat FSM stays IDLE.
- Idle timeout:
  - Stimulus: st_mux=2, no presses.
  - Required: st_mux returns to 0 after 20 idle cycles.
  - Stimulus: repeat with core_busy[2]=1 for 40 cycles.
  - Required: st_mux stays 2 throughout, then becomes 0 on the first cycle after busy drops.
- Reset mid-operation:
  - Stimulus: assert rst during an up repeat with st_mux=3.
  - Required: next edge gives st_mux=0 and no pulses. With btn_up still held, exactly one up_p occurs 7 edges after rst deasserts.

Source files
------------

// File: rtl/button_mode_sequencer_if.sv
// Button/command bundle between the raw button pins, the watch cores and
// the button_mode_sequencer.
//
// Signals:
//   btn_mode/btn_set/btn_up/btn_down : raw, asynchronous button levels
//   core_busy[3:0]                   : bit i high while core i is in a set/halt state
//   st_mux[1:0]                      : index of the core that owns the buttons
//   mode_p/set_p/up_p/down_p         : one-cycle command strobes
//   rpt_state[1:0]                   : debug view of the auto-repeat FSM (0 idle, 1 hold, 2 repeat)
//
// Handshake semantics: there is no valid/ready pair on this bundle. Each
// *_p output is a fire-and-forget strobe that is high for exactly one clock
// and at most one strobe is high in any cycle; the receiving core must take
// it in that cycle, because nothing is held or retried.
interface button_mode_sequencer_if;
  logic       btn_mode;
  logic       btn_set;
  logic       btn_up;
  logic       btn_down;
  logic [3:0] core_busy;
  logic [1:0] st_mux;
  logic       mode_p;
  logic       set_p;
  logic       up_p;
  logic       down_p;
  logic [1:0] rpt_state;

  modport master (
    output btn_mode, btn_set, btn_up, btn_down, core_busy,
    input  st_mux, mode_p, set_p, up_p, down_p, rpt_state
  );

  modport slave (
    input  btn_mode, btn_set, btn_up, btn_down, core_busy,
    output st_mux, mode_p, set_p, up_p, down_p, rpt_state
  );
endinterface

// File: rtl/button_mode_sequencer.sv
// Front-end controller for the watch cores. Synchronizes and debounces the
// four raw buttons, turns accepted presses into single-cycle commands,
// auto-repeats up/down while held, and owns st_mux (which core receives the
// commands), including an idle timeout that hands control back to core 0.
//
// Ports:
//   clk_tick : sole clock, rising edge
//   rst      : synchronous, active-high reset
//   btn_bus  : slave side of button_mode_sequencer_if (buttons, core_busy in;
//              st_mux, command strobes and repeat-FSM debug state out)
module button_mode_sequencer #(
  parameter int NUM_CORES    = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  parameter int IDLE_TICKS   = 3000
) (
  input  logic                   clk_tick,
  input  logic                   rst,
  button_mode_sequencer_if.slave btn_bus
);
  localparam int DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int IW   = $clog2(IDLE_TICKS + 1);

  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_TICKS);
  localparam logic [1:0]    LAST_CORE  = 2'(NUM_CORES - 1);
  localparam logic [3:0]    CORE_MASK  = 4'((1 << NUM_CORES) - 1);

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_HOLD   = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  // Button vectors are indexed [0] mode, [1] set, [2] up, [3] down.
  logic [3:0]    raw, s1, s2, deb, deb_d, press;
  logic [DW-1:0] dcnt [4];

  rpt_state_t    state, state_nx;
  logic          rkey, rkey_nx;          // latched repeat key: 0 up, 1 down
  logic [RW-1:0] rcnt, rcnt_nx, rpt_target;
  logic [IW-1:0] idle, idle_nx;
  logic [1:0]    st, st_nx;
  logic [3:0]    win, pulse_q;           // one-hot accepted event / registered strobes
  logic          key_held, rpt_fire, other_press, cur_busy;

  assign raw      = {btn_bus.btn_down, btn_bus.btn_up, btn_bus.btn_set, btn_bus.btn_mode};
  assign press    = deb & ~deb_d;
  assign cur_busy = (btn_bus.core_busy & CORE_MASK) >> st != 4'd0 ?
                    ((btn_bus.core_busy & CORE_MASK) >> st) & 4'd1 ? 1'b1 : 1'b0 : 1'b0;

  // Synchronizer + debounce: deb follows s2 only after DEBOUNCE consecutive
  // samples that disagree with it; any agreeing sample restarts the count.
  always_ff @(posedge clk_tick) begin
    if (rst) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 4; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Arbitration: a repeat tick is just another up/down event, so it loses to
  // a same-cycle mode or set press. Losers are dropped.
  always_comb begin
    key_held   = rkey ? deb[3] : deb[2];
    rpt_target = (state == RPT_HOLD) ? DELAY_LAST : RATE_LAST;
    rpt_fire   = (state != RPT_IDLE) && key_held && (rcnt == rpt_target);
    win        = 4'b0000;
    if (press[0])                        win[0] = 1'b1;
    else if (press[1])                   win[1] = 1'b1;
    else if (press[2] || (rpt_fire && !rkey)) win[2] = 1'b1;
    else if (press[3] || (rpt_fire && rkey))  win[3] = 1'b1;
  end

  // Repeat FSM next state.
  always_comb begin
    state_nx    = state;
    rkey_nx     = rkey;
    rcnt_nx     = rcnt;
    other_press = win[0] || win[1] || (win[2] && rkey) || (win[3] && !rkey);
    case (state)
      RPT_IDLE: begin
        if (win[2] || win[3]) begin
          state_nx = RPT_HOLD;
          rkey_nx  = win[3];
          rcnt_nx  = '0;
        end
      end
      RPT_HOLD, RPT_REPEAT: begin
        // Mode presses always count as "another key", which also covers a
        // mode-driven st_mux change.
        if (!key_held || other_press) begin
          state_nx = RPT_IDLE;
          rcnt_nx  = '0;
        end else if (rpt_fire) begin
          state_nx = RPT_REPEAT;
          rcnt_nx  = '0;
        end else if (rcnt != rpt_target) begin
          rcnt_nx = rcnt + 1'b1;
        end
      end
      default: begin
        state_nx = RPT_IDLE;
        rcnt_nx  = '0;
      end
    endcase
  end

  // Core selection and idle timeout. A mode press takes precedence over a
  // timeout in the same cycle; a busy core pins the timer at saturation.
  always_comb begin
    st_nx   = st;
    idle_nx = idle;
    if (win[0]) begin
      if (!cur_busy) st_nx = (st == LAST_CORE) ? 2'd0 : st + 2'd1;
      idle_nx = '0;
    end else if (win != 4'b0000) begin
      idle_nx = '0;
    end else if (idle == IDLE_MAX) begin
      if (st != 2'd0 && !cur_busy) begin
        st_nx   = 2'd0;
        idle_nx = '0;
      end
    end else begin
      idle_nx = idle + 1'b1;
    end
  end

  always_ff @(posedge clk_tick) begin
    if (rst) begin
      state   <= RPT_IDLE;
      rkey    <= 1'b0;
      rcnt    <= '0;
      idle    <= '0;
      st      <= 2'd0;
      pulse_q <= 4'b0000;
    end else begin
      state   <= state_nx;
      rkey    <= rkey_nx;
      rcnt    <= rcnt_nx;
      idle    <= idle_nx;
      st      <= st_nx;
      pulse_q <= win;
    end
  end

  assign btn_bus.st_mux    = st;
  assign btn_bus.mode_p    = pulse_q[0];
  assign btn_bus.set_p     = pulse_q[1];
  assign btn_bus.up_p      = pulse_q[2];
  assign btn_bus.down_p    = pulse_q[3];
  assign btn_bus.rpt_state = state;
endmodule

// File: tb/tb_button_mode_sequencer.sv
// Directed bench for button_mode_sequencer: a cycle-level behavioural model
// of the button rules feeds an expected queue that is compared against the
// DUT on every falling edge, plus literal checks of hand-computed timings.
module tb_button_mode_sequencer;
  localparam int NC  = 4;
  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RR  = 3;
  localparam int IT  = 20;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  button_mode_sequencer_if bus();

  button_mode_sequencer #(
    .NUM_CORES(NC), .DEBOUNCE(DEB), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .IDLE_TICKS(IT)
  ) dut (
    .clk_tick(clk),
    .rst     (rst),
    .btn_bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_lit(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packs {st_mux, down, up, set, mode} expected after each rising edge.
  logic [5:0] exp_q[$];
  logic [3:0] hist_q[$];     // raw button vector sampled at each edge
  logic [3:0] m_deb, m_rose;
  int m_cyc = 0, m_st = 0, m_last_clear = 0;
  int rep_key = -1, rep_last = 0, rep_n = 0;

  task automatic model_step();
    logic [3:0] raw, deb_pre, press, cand, h;
    int w, idle_t;
    bit busy, all_diff, rep_due;
    raw = {bus.btn_down, bus.btn_up, bus.btn_set, bus.btn_mode};
    m_cyc++;
    if (rst) begin
      hist_q.delete();
      for (int i = 0; i < 8; i++) hist_q.push_back(4'b0000);
      m_deb = '0; m_rose = '0; m_st = 0; m_last_clear = m_cyc;
      rep_key = -1; rep_n = 0; rep_last = 0;
      exp_q.push_back(6'b0);
    end else begin
      deb_pre = m_deb;
      press   = m_rose;      // a level accepted on the previous edge is a press now
      m_rose  = '0;
      // Level accepted once the last DEB synchronized samples all disagree.
      for (int b = 0; b < 4; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          h = hist_q[hist_q.size() - 2 - k];
          if (h[b] == m_deb[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_deb[b]  = ~m_deb[b];
          m_rose[b] = m_deb[b];
        end
      end
      hist_q.push_back(raw);
      if (hist_q.size() > 16) hist_q.delete(0);

      rep_due = 1'b0;
      if (rep_key >= 0)
        if (deb_pre[rep_key] && ((m_cyc - rep_last) == ((rep_n == 0) ? RD : RR)))
          rep_due = 1'b1;
      cand = press;
      if (rep_due) cand[rep_key] = 1'b1;
      w = -1;
      for (int b = 0; b < 4; b++) if (cand[b] && w < 0) w = b;

      busy   = (m_st < NC) && bus.core_busy[m_st];
      idle_t = m_cyc - 1 - m_last_clear;
      if (idle_t > IT) idle_t = IT;

      if (w >= 0) begin
        m_last_clear = m_cyc;
        if (w == 0 && !busy) m_st = (m_st + 1) % NC;
      end else if (idle_t == IT && m_st != 0 && !busy) begin
        m_st = 0;
        m_last_clear = m_cyc;
      end

      if (rep_key >= 0) begin
        if (!deb_pre[rep_key]) rep_key = -1;
        else if (w >= 0 && w != rep_key) rep_key = -1;
        else if (w == rep_key) begin rep_last = m_cyc; rep_n++; end
      end else if (w == 2 || w == 3) begin
        rep_key = w; rep_last = m_cyc; rep_n = 0;
      end
      exp_q.push_back({2'(m_st), w == 3, w == 2, w == 1, w == 0});
    end
  endtask

  initial begin : model_proc
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- scoreboard compare ----------------
  initial begin : compare_proc
    logic [5:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {bus.st_mux, bus.down_p, bus.up_p, bus.set_p, bus.mode_p};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL model_cmp cycle %0d: got st/dn/up/set/mode=%b, expected %b", cyc, got, e);
        end
      end
    end
  end

  // ---------------- pulse monitor ----------------
  int mode_cnt = 0, set_cnt = 0, up_cnt = 0, down_cnt = 0, down_last = -1;
  int up_cyc_q[$];

  initial begin : monitor_proc
    forever begin
      @(posedge clk);
      #1;
      if (bus.mode_p === 1'b1) mode_cnt++;
      if (bus.set_p  === 1'b1) set_cnt++;
      if (bus.up_p   === 1'b1) begin up_cnt++; up_cyc_q.push_back(cyc); end
      if (bus.down_p === 1'b1) begin down_cnt++; down_last = cyc; end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1;
    tick(8);
    bus.btn_mode = 1'b0;
    tick(8);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin : stim
    int c0, r, u0, m0, d0;
    rst = 1'b1;
    bus.btn_mode = 1'b0; bus.btn_set = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    bus.core_busy = 4'b0000;
    tick(3);
    check_lit("reset_st_mux", bus.st_mux, 0);
    check_lit("reset_pulses", {bus.mode_p, bus.set_p, bus.up_p, bus.down_p}, 0);
    rst = 1'b0;
    tick(2);

    // Debounce: 3-cycle glitch, then a clean 12-cycle press.
    bus.btn_set = 1'b1; tick(3); bus.btn_set = 1'b0; tick(12);
    check_lit("glitch_no_set", set_cnt, 0);
    c0 = cyc; bus.btn_set = 1'b1;
    tick(6); check_lit("set_p_edge6", bus.set_p, 0);
    tick(1); check_lit("set_p_edge7", bus.set_p, 1);
    tick(1); check_lit("set_p_edge8", bus.set_p, 0);
    tick(4); bus.btn_set = 1'b0; tick(8);
    check_lit("set_count", set_cnt, 1);

    // Mode wrap 1,2,3,0.
    for (int i = 1; i <= 4; i++) begin
      press_mode();
      check_lit("mode_wrap_st", bus.st_mux, i % 4);
    end
    check_lit("mode_count", mode_cnt, 4);

    // Busy core holds st_mux on a mode press.
    press_mode();
    check_lit("st_before_busy", bus.st_mux, 1);
    bus.core_busy = 4'b0010;
    press_mode();
    check_lit("busy_hold_st", bus.st_mux, 1);
    check_lit("busy_mode_p", mode_cnt, 6);
    bus.core_busy = 4'b0000;
    tick(15);
    check_lit("timeout_after_busy", bus.st_mux, 0);

    // Auto-repeat: first up_p at T=c0+7, repeats T+8, T+11, ... until release.
    up_cyc_q.delete();
    c0 = cyc; bus.btn_up = 1'b1;
    tick(37); bus.btn_up = 1'b0;
    tick(20);
    check_lit("rpt_count", up_cyc_q.size(), 11);
    if (up_cyc_q.size() >= 11) begin
      check_lit("rpt_first",  up_cyc_q[0]  - c0, 7);
      check_lit("rpt_second", up_cyc_q[1]  - c0, 15);
      check_lit("rpt_third",  up_cyc_q[2]  - c0, 18);
      check_lit("rpt_fourth", up_cyc_q[3]  - c0, 21);
      check_lit("rpt_last",   up_cyc_q[10] - c0, 42);
    end

    // Down press during up repeat stops the repeat.
    up_cyc_q.delete(); d0 = down_cnt;
    c0 = cyc; bus.btn_up = 1'b1;
    tick(12); bus.btn_down = 1'b1;
    tick(30);
    check_lit("down_stop_up_count", up_cyc_q.size(), 3);
    check_lit("down_once", down_cnt - d0, 1);
    check_lit("down_cycle", down_last - c0, 19);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    tick(12);

    // Priority: mode and up rise together.
    m0 = mode_cnt; u0 = up_cnt;
    bus.btn_mode = 1'b1; bus.btn_up = 1'b1;
    tick(7);
    check_lit("prio_mode_p", bus.mode_p, 1);
    check_lit("prio_up_p", bus.up_p, 0);
    check_lit("prio_rpt_idle", bus.rpt_state, 0);
    tick(15);
    check_lit("prio_no_up", up_cnt - u0, 0);
    check_lit("prio_one_mode", mode_cnt - m0, 1);
    bus.btn_mode = 1'b0; bus.btn_up = 1'b0;
    tick(10);

    // Idle timeout from core 2.
    do_reset();
    press_mode();
    bus.btn_mode = 1'b1;
    tick(7);
    check_lit("idle_st2", bus.st_mux, 2);
    tick(13); bus.btn_mode = 1'b0;
    tick(7);
    check_lit("idle_st_at20", bus.st_mux, 2);
    tick(1);
    check_lit("idle_st_at21", bus.st_mux, 0);

    // Idle timeout held off while core 2 is busy.
    do_reset();
    press_mode();
    bus.btn_mode = 1'b1;
    tick(7);
    bus.core_busy = 4'b0100;
    tick(6); bus.btn_mode = 1'b0;
    tick(34);
    check_lit("busy_idle_st2", bus.st_mux, 2);
    bus.core_busy = 4'b0000;
    tick(1);
    check_lit("busy_idle_return", bus.st_mux, 0);

    // Reset during an up repeat with st_mux=3.
    do_reset();
    press_mode(); press_mode(); press_mode();
    check_lit("rst_mid_st3", bus.st_mux, 3);
    bus.btn_up = 1'b1;
    tick(20);
    rst = 1'b1;
    tick(1);
    check_lit("rst_mid_st0", bus.st_mux, 0);
    check_lit("rst_mid_pulses", {bus.mode_p, bus.set_p, bus.up_p, bus.down_p}, 0);
    rst = 1'b0;
    u0 = up_cnt;
    tick(6); check_lit("rst_up_edge6", bus.up_p, 0);
    tick(1); check_lit("rst_up_edge7", bus.up_p, 1);
    tick(7); check_lit("rst_up_once", up_cnt - u0, 1);
    bus.btn_up = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
